conv_stream_engine: RTL and testbench

- Parametrised successor of the stage-2 convolution slice: computes a full valid-mode KxK convolution of an IN_CH x IN_DIM x IN_DIM tensor against NUM_FILT filters, with per-filter bias and ReLU.
- Sequences all output positions itself under a start/done handshake.
- Streams results with a valid/ready handshake that supports backpressure, instead of writing a wide register bank.
- Sits between the tensor buffer and the next layer's input FIFO.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_window_mac.sv | 62 ++++++
 rtl/conv_stream_engine.sv | 196 +++++++++++++++++++
 tb/tb_conv_stream_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} conv_state_e;

    function automatic int unsigned conv_acc_w(input int unsigned data_w,
                                               input int unsigned in_ch,
                                               input int unsigned k);
        return 2 * data_w + $clog2(in_ch * k * k) + 1;
    endfunction

    function automatic int unsigned conv_out_dim(input int unsigned in_dim,
                                                 input int unsigned k);
        return in_dim - k + 1;
    endfunction

    // Filter-major linear address of one output element.
    function automatic int unsigned conv_out_addr(input int unsigned f,
                                                  input int unsigned r,
                                                  input int unsigned c,
                                                  input int unsigned out_dim);
        return f * out_dim * out_dim + r * out_dim + c;
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// Two pipeline stages for one KxK window: registered products, then a
// sign-extended sum plus bias.
module conv_window_mac
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = 17,
    parameter int unsigned IN_CH  = 3,
    parameter int unsigned K      = 3,
    parameter int unsigned ACC_W  = conv_acc_w(DATA_W, IN_CH, K)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [IN_CH*K*K*DATA_W-1:0]      window,
    input  logic [IN_CH*K*K*DATA_W-1:0]      taps,
    input  logic [DATA_W-1:0]                bias,
    output logic signed [ACC_W-1:0]          sum
);

    localparam int unsigned TAPS   = IN_CH * K * K;
    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [DATA_W-1:0] bias_q;
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum_q;

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod_d[i] = PROD_W'($signed(window[i*DATA_W +: DATA_W]))
                      * PROD_W'($signed(taps[i*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        sum_d = ACC_W'(bias_q);
        for (int i = 0; i < TAPS; i++) begin
            sum_d = sum_d + ACC_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= '0;
            end
            bias_q <= '0;
            sum_q  <= '0;
        end else if (en) begin
            for (int i = 0; i < TAPS; i++) begin
                prod_q[i] <= prod_d[i];
            end
            // Bias rides along with the products so it stays aligned to its filter.
            bias_q <= $signed(bias);
            sum_q  <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/conv_stream_engine.sv
// Valid-mode KxK convolution with bias and ReLU, streamed out filter-major under
// valid/ready backpressure. Optional output saturation: CONV_STREAM_SAT_EN.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W   = 17,
    parameter int unsigned IN_CH    = 3,
    parameter int unsigned IN_DIM   = 8,
    parameter int unsigned K        = 3,
    parameter int unsigned NUM_FILT = 4,
    parameter int unsigned ACC_W    = conv_acc_w(DATA_W, IN_CH, K),
    localparam int unsigned OUT_DIM = conv_out_dim(IN_DIM, K),
    localparam int unsigned NUM_OUT = NUM_FILT * OUT_DIM * OUT_DIM,
    localparam int unsigned ADDR_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    input  logic [IN_CH*IN_DIM*IN_DIM*DATA_W-1:0] in_tensor,
    input  logic [NUM_FILT*IN_CH*K*K*DATA_W-1:0] weights,
    input  logic [NUM_FILT*DATA_W-1:0]           bias,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ACC_W-1:0]                     out_data,
    output logic [ADDR_W-1:0]                    out_addr
`ifdef CONV_STREAM_SAT_EN
    ,
    output logic                                 sat_seen
`endif
);

    localparam int unsigned TAPS = IN_CH * K * K;
    localparam int unsigned OD_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int unsigned F_W  = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;

    conv_state_e        state_q;
    logic [F_W-1:0]     f_q;
    logic [OD_W-1:0]    r_q, c_q;
    logic               busy_q, done_q;
    logic               v1_q, v2_q, v3_q;
    logic [ADDR_W-1:0]  a1_q, a2_q, a3_q;
    logic [ACC_W-1:0]   data_q;

    logic               adv, issue, last_win, drained;
    logic [ADDR_W-1:0]  addr_now;
    logic [TAPS*DATA_W-1:0] window, taps;
    logic [DATA_W-1:0]  bias_sel;
    logic signed [ACC_W-1:0] s2_sum;
    logic [ACC_W-1:0]   relu, res_d;

    // A held output beat freezes the whole pipeline and the window counters.
    assign adv      = !(v3_q && !out_ready);
    assign issue    = (state_q == StRun) && adv;
    assign last_win = (f_q == F_W'(NUM_FILT - 1)) && (r_q == OD_W'(OUT_DIM - 1))
                   && (c_q == OD_W'(OUT_DIM - 1));
    assign drained  = !v1_q && !v2_q && (!v3_q || out_ready);
    assign addr_now = ADDR_W'(conv_out_addr(32'(f_q), 32'(r_q), 32'(c_q), OUT_DIM));

    always_comb begin
        window = '0;
        for (int ch = 0; ch < IN_CH; ch++) begin
            for (int kr = 0; kr < K; kr++) begin
                for (int kc = 0; kc < K; kc++) begin
                    window[((ch*K + kr)*K + kc)*DATA_W +: DATA_W] =
                        in_tensor[((ch*IN_DIM + int'(r_q) + kr)*IN_DIM + int'(c_q) + kc)*DATA_W
                                  +: DATA_W];
                end
            end
        end
    end

    assign taps     = weights[int'(f_q)*TAPS*DATA_W +: TAPS*DATA_W];
    assign bias_sel = bias[int'(f_q)*DATA_W +: DATA_W];

    conv_window_mac #(
        .DATA_W (DATA_W),
        .IN_CH  (IN_CH),
        .K      (K),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .en     (adv),
        .window (window),
        .taps   (taps),
        .bias   (bias_sel),
        .sum    (s2_sum)
    );

    assign relu = s2_sum[ACC_W-1] ? '0 : s2_sum;

`ifdef CONV_STREAM_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    logic clamp;
    logic sat_q;
    assign clamp = relu > SAT_MAX;
    assign res_d = clamp ? SAT_MAX : relu;
`else
    assign res_d = relu;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        f_q     <= '0;
                        r_q     <= '0;
                        c_q     <= '0;
                    end
                end
                StRun: begin
                    if (adv) begin
                        if (c_q == OD_W'(OUT_DIM - 1)) begin
                            c_q <= '0;
                            if (r_q == OD_W'(OUT_DIM - 1)) begin
                                r_q <= '0;
                                f_q <= (f_q == F_W'(NUM_FILT - 1)) ? '0 : f_q + F_W'(1);
                            end else begin
                                r_q <= r_q + OD_W'(1);
                            end
                        end else begin
                            c_q <= c_q + OD_W'(1);
                        end
                        if (last_win) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drained) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            a1_q   <= '0;
            a2_q   <= '0;
            a3_q   <= '0;
            data_q <= '0;
        end else if (adv) begin
            v1_q <= issue;
            if (issue) a1_q <= addr_now;
            v2_q <= v1_q;
            a2_q <= a1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                a3_q   <= a2_q;
                data_q <= res_d;
            end
        end
    end

`ifdef CONV_STREAM_SAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            sat_q <= 1'b0;
        end else if (adv && v2_q && clamp) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_seen = sat_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = v3_q;
    assign out_addr  = a3_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench for conv_stream_engine against a loop-based convolution model.
// Build with +define+CONV_STREAM_SAT_EN to cover the saturating variant.
module tb_conv_stream_engine;

    localparam int DW     = 17;
    localparam int IN_CH  = 3;
    localparam int IN_DIM = 8;
    localparam int K      = 3;
    localparam int NF     = 4;
    localparam int OD     = IN_DIM - K + 1;
    localparam int NOUT   = NF * OD * OD;
    localparam int ACC_W  = 2 * DW + $clog2(IN_CH * K * K) + 1;
    localparam int AW     = $clog2(NOUT);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic busy, done, out_valid;
    logic [ACC_W-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic [IN_CH*IN_DIM*IN_DIM*DW-1:0] in_tensor;
    logic [NF*IN_CH*K*K*DW-1:0] weights;
    logic [NF*DW-1:0] bias;
`ifdef CONV_STREAM_SAT_EN
    logic sat_seen;
`endif

    int act [IN_CH][IN_DIM][IN_DIM];
    int wt  [NF][IN_CH][K][K];
    int bs  [NF];
    longint exp_q [$];
    int checks = 0;
    int errors = 0;

    conv_stream_engine #(
        .DATA_W   (DW),
        .IN_CH    (IN_CH),
        .IN_DIM   (IN_DIM),
        .K        (K),
        .NUM_FILT (NF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_tensor (in_tensor),
        .weights   (weights),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr)
`ifdef CONV_STREAM_SAT_EN
        ,
        .sat_seen  (sat_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int rnd17();
        return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
    endfunction

    // Plain convolution + bias + ReLU (+ clamp) straight from the arrays.
    function automatic longint ref_val(input int f, input int r, input int c);
        longint acc = longint'(bs[f]);
        for (int ch = 0; ch < IN_CH; ch++)
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++)
                    acc += longint'(act[ch][r+kr][c+kc]) * longint'(wt[f][ch][kr][kc]);
        if (acc < 0) acc = 0;
`ifdef CONV_STREAM_SAT_EN
        if (acc > longint'((1 << (DW - 1)) - 1)) acc = longint'((1 << (DW - 1)) - 1);
`endif
        return acc;
    endfunction

    task automatic build_model();
        for (int ch = 0; ch < IN_CH; ch++)
            for (int r = 0; r < IN_DIM; r++)
                for (int c = 0; c < IN_DIM; c++)
                    in_tensor[((ch*IN_DIM + r)*IN_DIM + c)*DW +: DW] = DW'(act[ch][r][c]);
        for (int f = 0; f < NF; f++) begin
            bias[f*DW +: DW] = DW'(bs[f]);
            for (int ch = 0; ch < IN_CH; ch++)
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        weights[(((f*IN_CH + ch)*K + kr)*K + kc)*DW +: DW] = DW'(wt[f][ch][kr][kc]);
        end
        exp_q.delete();
        for (int f = 0; f < NF; f++)
            for (int r = 0; r < OD; r++)
                for (int c = 0; c < OD; c++)
                    exp_q.push_back(ref_val(f, r, c));
    endtask

    task automatic fill(input int a, input int w, input int b);
        for (int ch = 0; ch < IN_CH; ch++)
            for (int r = 0; r < IN_DIM; r++)
                for (int c = 0; c < IN_DIM; c++)
                    act[ch][r][c] = a;
        for (int f = 0; f < NF; f++) begin
            bs[f] = b;
            for (int ch = 0; ch < IN_CH; ch++)
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        wt[f][ch][kr][kc] = w;
        end
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < IN_CH; ch++)
            for (int r = 0; r < IN_DIM; r++)
                for (int c = 0; c < IN_DIM; c++)
                    act[ch][r][c] = rnd17();
        for (int f = 0; f < NF; f++) begin
            bs[f] = rnd17();
            for (int ch = 0; ch < IN_CH; ch++)
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        wt[f][ch][kr][kc] = rnd17();
        end
    endtask

    // One pass from start to done. abort_at > 0 pulls reset after that many beats.
    task automatic run_pass(input bit rnd_ready, input int abort_at,
                            input bit start_at_done, input bit check_latency);
        int beats = 0;
        int cyc = 1;
        int last_acc = -1;
        int done_cyc = -1;
        int first_valid = -1;
        bit prev_stall = 1'b0;
        bit quiet_bad = 1'b0;
        logic [ACC_W-1:0] pd = '0;
        logic [AW-1:0] pa = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (cyc < 3000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (prev_stall) begin
                check("stall_valid_hold", out_valid, 1);
                check("stall_data_hold", out_data, pd);
                check("stall_addr_hold", out_addr, pa);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (cyc == 20);
            if (out_valid && out_ready) begin
                if (beats < NOUT) begin
                    check("beat_addr", out_addr, beats);
                    check("beat_data", out_data, exp_q[beats]);
                end else begin
                    check("extra_beat", beats, NOUT - 1);
                end
                beats++;
                last_acc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pa = out_addr;
            if (abort_at > 0 && beats == abort_at) begin
                start = 1'b0;
                reset = 1'b0;
                #1;
                check("abort_valid", out_valid, 0);
                check("abort_data", out_data, 0);
                check("abort_addr", out_addr, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                @(negedge clk);
                reset = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (done || out_valid || busy) quiet_bad = 1'b1;
                end
                check("abort_quiet", quiet_bad, 0);
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("beat_count", beats, NOUT);
        check("done_timing", done_cyc, last_acc + 1);
        if (check_latency) check("first_valid_latency", first_valid, 4);
        if (start_at_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        if (start_at_done) begin
            repeat (8) begin
                @(negedge clk);
                if (busy || out_valid || done) quiet_bad = 1'b1;
            end
            check("start_at_done_ignored", quiet_bad, 0);
        end
    endtask

    initial begin
        in_tensor = '0;
        weights = '0;
        bias = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_addr", out_addr, 0);
`ifdef CONV_STREAM_SAT_EN
        check("rst_sat", sat_seen, 0);
`endif
        reset = 1'b1;

        fill(1, 1, 0);
        build_model();
        run_pass(1'b0, 0, 1'b0, 1'b1);
`ifdef CONV_STREAM_SAT_EN
        check("sat_clear_small", sat_seen, 0);
`endif

        fill(1, 1, 0);
        bs[2] = -30;
        build_model();
        run_pass(1'b0, 0, 1'b0, 1'b0);

        fill(0, 0, 0);
        for (int ch = 0; ch < IN_CH; ch++)
            for (int r = 0; r < IN_DIM; r++)
                for (int c = 0; c < IN_DIM; c++)
                    act[ch][r][c] = r * IN_DIM + c;
        wt[0][0][K/2][K/2] = 1;
        build_model();
        run_pass(1'b0, 0, 1'b1, 1'b0);

        fill_random();
        build_model();
        run_pass(1'b1, 0, 1'b0, 1'b1);

        fill_random();
        build_model();
        run_pass(1'b1, 60, 1'b0, 1'b0);
        run_pass(1'b0, 0, 1'b0, 1'b0);

        fill(65535, 65535, 0);
        build_model();
        run_pass(1'b1, 0, 1'b0, 1'b0);
`ifdef CONV_STREAM_SAT_EN
        check("sat_seen_set", sat_seen, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
